// File: rtl/aes_block_packer_pkg.sv
// Shared types and constants for the AES plaintext byte-to-block packer.
// Optional PKCS#7 padding helper is used when AES_PACK_PKCS7_EN is defined.
package aes_pkg;

  localparam int AES_BLK_BYTES = 16;

  typedef logic [127:0] aes_blk_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } aes_pack_st_e;

  // Left-aligns the n collected bytes and fills the k = 16-n free bytes with the value k.
  function automatic aes_blk_t pkcs7_pad(aes_blk_t blk, logic [4:0] n);
    logic [4:0] k;
    aes_blk_t   pad;
    k   = 5'(AES_BLK_BYTES) - n;
    pad = '0;
    for (int i = 0; i < AES_BLK_BYTES; i++) begin
      if (i < int'(k)) pad[8*i +: 8] = {3'b000, k};
    end
    return (blk << {k, 3'b000}) | pad;
  endfunction

endpackage

// File: rtl/aes_block_packer_if.sv
// Byte-stream valid/ready channel feeding the AES block packer.
interface aes_block_packer_if;

  logic       s_valid_i;
  logic       s_ready_o;
  logic [7:0] s_data_i;
  logic       s_last_i;

  modport master (
    output s_valid_i,
    output s_data_i,
    output s_last_i,
    input  s_ready_o
  );

  modport slave (
    input  s_valid_i,
    input  s_data_i,
    input  s_last_i,
    output s_ready_o
  );

endinterface

// File: rtl/aes_block_packer.sv
// Packs a plaintext byte stream into 128-bit blocks and issues them to the AES encryptor.
// Define AES_PACK_PKCS7_EN to pad a short final block (flagged by s_last_i) with PKCS#7.
module aes_block_packer
  import aes_pkg::*;
#(
  parameter int WIDTH = 128
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  aes_block_packer_if.slave  s_if,
  input  logic               enc_busy_i,
  input  logic               enc_done_i,
  output logic [WIDTH-1:0]   plaintext_o,
  output logic               data_valid_o,
  output logic [15:0]        blk_cnt_o
);

  aes_pack_st_e state_q, state_d;
  aes_blk_t     shreg_q, shreg_d;
  aes_blk_t     hold_q, hold_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         hold_full_q, hold_full_d;
  logic [15:0]  blk_cnt_q, blk_cnt_d;

  logic accept, xfer, release_blk, pad_busy;

`ifdef AES_PACK_PKCS7_EN
  logic pad_pend_q, pad_pend_d;
  assign pad_busy = pad_pend_q;
`else
  logic unused_last;
  assign unused_last = s_if.s_last_i;
  assign pad_busy    = 1'b0;
`endif

  assign s_if.s_ready_o = (cnt_q < 5'(AES_BLK_BYTES)) && !pad_busy;
  assign accept         = s_if.s_valid_i && s_if.s_ready_o;
  // hold_full_q is the registered flag, so a block freed this cycle moves up next cycle.
  assign xfer           = (cnt_q == 5'(AES_BLK_BYTES)) && !hold_full_q;
  assign release_blk    = (state_q == WAIT) && enc_done_i;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef AES_PACK_PKCS7_EN
    pad_pend_d = pad_pend_q;
`endif
    if (accept) begin
      shreg_d = {shreg_q[119:0], s_if.s_data_i};
      cnt_d   = cnt_q + 5'd1;
`ifdef AES_PACK_PKCS7_EN
      if (s_if.s_last_i && (cnt_q < 5'd15)) pad_pend_d = 1'b1;
`endif
    end
`ifdef AES_PACK_PKCS7_EN
    else if (pad_pend_q) begin
      shreg_d    = pkcs7_pad(shreg_q, cnt_q);
      cnt_d      = 5'(AES_BLK_BYTES);
      pad_pend_d = 1'b0;
    end
`endif
    else if (xfer) begin
      cnt_d = '0;
    end
  end

  always_comb begin
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    blk_cnt_d   = blk_cnt_q;
    if (xfer) begin
      hold_d      = shreg_q;
      hold_full_d = 1'b1;
    end else if (release_blk) begin
      hold_full_d = 1'b0;
    end
    if (release_blk) blk_cnt_d = blk_cnt_q + 16'd1;
  end

  // Leaving IDLE on the transfer itself lets data_valid_o rise the cycle after it.
  always_comb begin
    state_d      = state_q;
    data_valid_o = 1'b0;
    unique case (state_q)
      IDLE:  if (hold_full_q || xfer) state_d = ISSUE;
      ISSUE: begin
        data_valid_o = 1'b1;
        if (enc_busy_i) state_d = WAIT;
      end
      WAIT:  if (enc_done_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
  // NOTE: the data registers are reset too, so plaintext_o reads zero and no stale block leaks after reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q     <= IDLE;
      shreg_q     <= '0;
      hold_q      <= '0;
      cnt_q       <= '0;
      hold_full_q <= 1'b0;
      blk_cnt_q   <= '0;
`ifdef AES_PACK_PKCS7_EN
      pad_pend_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      hold_q      <= hold_d;
      cnt_q       <= cnt_d;
      hold_full_q <= hold_full_d;
      blk_cnt_q   <= blk_cnt_d;
`ifdef AES_PACK_PKCS7_EN
      pad_pend_q  <= pad_pend_d;
`endif
    end
  end

  assign plaintext_o = hold_q;
  assign blk_cnt_o   = blk_cnt_q;

endmodule

// File: tb/tb_aes_block_packer.sv
// Directed self-checking bench for aes_block_packer: single block, last-byte handling,
// backpressure, reset mid-fill and spurious encryptor strobes.
module tb_aes_block_packer;
  import aes_pkg::*;

  logic         clk_i       = 1'b0;
  logic         rst_n_i     = 1'b0;
  logic         enc_busy_i  = 1'b0;
  logic         enc_done_i  = 1'b0;
  logic [127:0] plaintext_o;
  logic         data_valid_o;
  logic [15:0]  blk_cnt_o;

  aes_block_packer_if s_if ();

  aes_block_packer #(.WIDTH(128)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .s_if         (s_if),
    .enc_busy_i   (enc_busy_i),
    .enc_done_i   (enc_done_i),
    .plaintext_o  (plaintext_o),
    .data_valid_o (data_valid_o),
    .blk_cnt_o    (blk_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;
  int first_done_cyc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Presents one byte and returns at the negedge after it was accepted.
  task automatic push(input logic [7:0] b, input logic last);
    int g = 0;
    s_if.s_valid_i = 1'b1;
    s_if.s_data_i  = b;
    s_if.s_last_i  = last;
    while (s_if.s_ready_o !== 1'b1 && g < 300) begin
      @(negedge clk_i);
      g++;
    end
    if (g >= 300) check("push_ready_timeout", s_if.s_ready_o, 1);
    @(negedge clk_i);
  endtask

  task automatic idle_in();
    s_if.s_valid_i = 1'b0;
    s_if.s_last_i  = 1'b0;
  endtask

  task automatic push_block(input aes_blk_t blk, input logic last_on_end);
    for (int i = 0; i < 16; i++) push(blk[127-8*i -: 8], last_on_end && (i == 15));
    idle_in();
  endtask

  // Minimal encryptor: waits for data_valid_o, stays busy lat cycles, then pulses done.
  task automatic enc_run(input int lat, output aes_blk_t pt);
    int g = 0;
    while (data_valid_o !== 1'b1 && g < 300) begin
      @(negedge clk_i);
      g++;
    end
    check("enc_dv_seen", data_valid_o, 1);
    pt = plaintext_o;
    enc_busy_i = 1'b1;
    repeat (lat) @(negedge clk_i);
    enc_busy_i = 1'b0;
    enc_done_i = 1'b1;
    if (first_done_cyc < 0) first_done_cyc = cyc;
    @(negedge clk_i);
    enc_done_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  aes_blk_t pt, got0, got1, got2;
  logic     rdy_after32;
  int       rdy_cyc;
  int       g;

  initial begin
    s_if.s_valid_i = 1'b0;
    s_if.s_data_i  = 8'h00;
    s_if.s_last_i  = 1'b0;
    first_done_cyc = -1;
    rdy_cyc        = -1;
    rdy_after32    = 1'bx;

    // Reset values
    repeat (2) @(negedge clk_i);
    check("rst_ready", s_if.s_ready_o, 1);
    check("rst_dv", data_valid_o, 0);
    check("rst_pt", plaintext_o, 0);
    check("rst_blk_cnt", blk_cnt_o, 0);
    rst_n_i = 1'b1;
    @(negedge clk_i);

    // Single block: FIPS-197 byte order and issue latency
    push_block(128'h3243f6a8885a308d313198a2e0370734, 1'b0);
    check("sb_dv_n1", data_valid_o, 0);
    @(negedge clk_i);
    check("sb_dv_n2", data_valid_o, 1);
    check("sb_pt", plaintext_o, 128'h3243f6a8885a308d313198a2e0370734);
    enc_busy_i = 1'b1;
    @(negedge clk_i);
    check("sb_dv_drop", data_valid_o, 0);
    repeat (3) @(negedge clk_i);
    enc_busy_i = 1'b0;
    enc_done_i = 1'b1;
    @(negedge clk_i);
    enc_done_i = 1'b0;
    check("sb_blk_cnt", blk_cnt_o, 1);
    check("sb_pt_after", plaintext_o, 128'h3243f6a8885a308d313198a2e0370734);

    // Short last block
`ifdef AES_PACK_PKCS7_EN
    for (int i = 0; i < 13; i++) push(8'(i), i == 12);
    idle_in();
    enc_run(4, pt);
    check("pkcs7_pt", pt, 128'h000102030405060708090a0b0c030303);
`else
    for (int i = 0; i < 16; i++) push(8'(i), i == 12);
    idle_in();
    enc_run(4, pt);
    check("last_ignored_pt", pt, 128'h000102030405060708090a0b0c0d0e0f);
`endif
    check("short_blk_cnt", blk_cnt_o, 2);

    // Exact multiple with last: exactly one block, no pad block
    push_block(128'h00112233445566778899aabbccddeeff, 1'b1);
    enc_run(4, pt);
    check("exact_pt", pt, 128'h00112233445566778899aabbccddeeff);
    repeat (6) @(negedge clk_i);
    check("exact_no_pad_dv", data_valid_o, 0);
    check("exact_ready", s_if.s_ready_o, 1);
    check("exact_blk_cnt", blk_cnt_o, 3);

    // Backpressure: 48 bytes streamed against a 20-cycle encryptor
    first_done_cyc = -1;
    fork
      begin
        for (int i = 0; i < 48; i++) begin
          if (i == 32) begin
            idle_in();
            rdy_after32 = s_if.s_ready_o;
            g = 0;
            while (s_if.s_ready_o !== 1'b1 && g < 300) begin
              @(negedge clk_i);
              g++;
            end
            rdy_cyc = cyc;
          end
          push(8'(8'h40 + i), 1'b0);
        end
        idle_in();
      end
      begin
        enc_run(20, got0);
        enc_run(20, got1);
        enc_run(20, got2);
      end
    join
    check("bp_ready_low_after32", rdy_after32, 0);
    check("bp_ready_reopen_cyc", rdy_cyc, first_done_cyc + 2);
    check("bp_blk0", got0, 128'h404142434445464748494a4b4c4d4e4f);
    check("bp_blk1", got1, 128'h505152535455565758595a5b5c5d5e5f);
    check("bp_blk2", got2, 128'h606162636465666768696a6b6c6d6e6f);
    check("bp_blk_cnt", blk_cnt_o, 6);

    // Reset mid-fill discards the partial block
    for (int i = 0; i < 7; i++) push(8'(8'ha0 + i), 1'b0);
    idle_in();
    rst_n_i = 1'b0;
    @(negedge clk_i);
    rst_n_i = 1'b1;
    check("mid_rst_blk_cnt", blk_cnt_o, 0);
    check("mid_rst_ready", s_if.s_ready_o, 1);
    check("mid_rst_pt", plaintext_o, 0);
    push_block(128'hf0e0d0c0b0a090807060504030201000, 1'b0);
    enc_run(5, pt);
    check("mid_rst_fresh_pt", pt, 128'hf0e0d0c0b0a090807060504030201000);
    check("mid_rst_blk_cnt_after", blk_cnt_o, 1);

    // Spurious encryptor strobes in IDLE
    enc_done_i = 1'b1;
    @(negedge clk_i);
    enc_done_i = 1'b0;
    check("spur_done_blk_cnt", blk_cnt_o, 1);
    check("spur_done_state", dut.state_q, IDLE);
    enc_busy_i = 1'b1;
    @(negedge clk_i);
    enc_busy_i = 1'b0;
    check("spur_busy_state", dut.state_q, IDLE);
    check("spur_busy_dv", data_valid_o, 0);
    enc_busy_i = 1'b1;
    enc_done_i = 1'b1;
    @(negedge clk_i);
    enc_busy_i = 1'b0;
    enc_done_i = 1'b0;
    check("spur_both_blk_cnt", blk_cnt_o, 1);
    check("spur_both_state", dut.state_q, IDLE);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/aes_block_packer.md
# aes_block_packer

Upstream input stage for `AES128_Encryptor`. Accepts plaintext as a byte stream over a valid/ready handshake and assembles each 16 bytes into one 128-bit block. Presents each block on the encryptor's `plaintext_i`/`data_valid_i` pair and holds it until the encryptor reports completion. A second staging register lets the next block fill while the current one encrypts. The key path (`key_i`/`key_valid_i`) is driven separately and is not handled here.

## Interface
- `WIDTH`, 128, block width in bits; must be 128. Byte count is `WIDTH/8` = 16.
- `clk_i`  in  1  clock; all logic is rising-edge.
- `rst_n_i`  in  1  reset, synchronous, active-low.
- `s_valid_i`  in  1  input byte valid.
- `s_ready_o`  out  1  packer can accept a byte this cycle.
- `s_data_i`  in  8  input byte.
- `s_last_i`  in  1  final byte of the message. Qualified by `s_valid_i && s_ready_o`.
- `enc_busy_i`  in  1  from encryptor `busy_o`.
- `enc_done_i`  in  1  from encryptor `data_ready_o`; ciphertext is valid.
- `plaintext_o`  out  WIDTH  to encryptor `plaintext_i`.
- `data_valid_o`  out  1  to encryptor `data_valid_i`.
- `blk_cnt_o`  out  16  count of completed blocks; wraps 0xFFFF→0.

## Operation
- **Fill register `shreg` and counter `cnt` (0..16).**
  - A byte is accepted when `s_valid_i && s_ready_o`.
  - On accept: `shreg <= {shreg[119:0], s_data_i}`, `cnt <= cnt+1`.
  - The first byte of a block therefore lands in bits [127:120], matching FIPS-197 byte order.
  - `s_ready_o = (cnt < 16) && !pad_pend`.
- **Transfer to hold register.**
  - Fires when `cnt == 16 && !hold_full`.
  - Actions: `hold <= shreg`, `hold_full <= 1`, `cnt <= 0`.
- **Issue FSM.** States: IDLE, ISSUE, WAIT.
  - IDLE: `data_valid_o = 0`. Goes to ISSUE when `hold_full`.
  - ISSUE: `data_valid_o = 1`. Goes to WAIT on the first cycle `enc_busy_i == 1`.
  - WAIT: `data_valid_o = 0`. When `enc_done_i == 1`: `hold_full <= 0`, `blk_cnt_o++`, go to IDLE.
  - `plaintext_o = hold` in every state. `hold` is stable from transfer until release.
- **Simultaneous events.**
  - Transfer tests `hold_full` as registered, so a block freed by `enc_done_i` transfers one cycle later.
  - `enc_done_i` seen outside WAIT is ignored.
  - `enc_busy_i` seen in IDLE is ignored.
- **`s_last_i` without the padding feature.** Ignored. The message length must be a multiple of 16 bytes.
- **Reset mid-operation.** Any partial block or held block is discarded. Any encryption in flight is ignored on return to IDLE.

## Timing
- **Reset values:**
  - `s_ready_o = 1`
  - `data_valid_o = 0`
  - `plaintext_o = 0`
  - `blk_cnt_o = 0`
  - FSM in IDLE, `cnt = 0`, `hold_full = 0`, `pad_pend = 0`
- **Latency:**
  - 16th byte accepted in cycle N → transfer in N+1 → `data_valid_o` high in N+2.
  - `enc_done_i` in cycle M → `blk_cnt_o` updates and `hold_full` clears in M+1.
  - If `shreg` is already full, transfer happens in M+1 and `data_valid_o` rises in M+2.
- **Backpressure:** `s_ready_o` stays low while `cnt == 16` and `hold` is occupied.
- **Sustained throughput:** bounded by encryptor latency, not by the packer.

## Configuration
- **Macro:** `AES_PACK_PKCS7_EN`.
- **Defined:**
  - An accepted byte with `s_last_i = 1` that leaves `cnt = n < 16` sets `pad_pend`.
  - The next cycle pads the block in one step, with k = 16−n: `shreg <= (shreg << 8k) | {k{8'(k)}}`, `cnt <= 16`, `pad_pend <= 0`.
  - `s_ready_o` is low during that cycle.
  - `s_last_i` with `n == 16` adds no pad block.
- **Undefined:** no padding logic, no `pad_pend`. The `s_last_i` port remains but is unused.

## Structure
- **Package `aes_pkg`:**
  - `AES_BLK_BYTES = 16`
  - `aes_blk_t` = `logic [127:0]`
  - issue-FSM state enum `aes_pack_st_e` {IDLE, ISSUE, WAIT}
- **Single module, no sub-modules.** The issue FSM is small enough to stay inline.

## Test plan
- **Single block.**
  - Stimulus: bytes 32 43 f6 a8 88 5a 30 8d 31 31 98 a2 e0 37 07 34, one per cycle.
  - Expected: `plaintext_o = 128'h3243f6a8885a308d313198a2e0370734`, `data_valid_o` high 2 cycles after the last byte.
  - Expected: `data_valid_o` drops after `enc_busy_i` rises, `blk_cnt_o = 1` after `enc_done_i`.
- **Backpressure.**
  - Stimulus: stream 48 bytes back-to-back with encryptor latency 20 cycles.
  - Expected: `s_ready_o` low after byte 32 until the first `enc_done_i` + 1 cycle.
  - Expected: three blocks issued in order, `blk_cnt_o = 3`.
- **PKCS#7, defined.**
  - Stimulus: 13 bytes 00..0c with `s_last_i` on the 13th.
  - Expected: `plaintext_o = 128'h000102030405060708090a0b0c030303`.
- **Exact-multiple last, defined.**
  - Stimulus: 16 bytes with `s_last_i` on the 16th.
  - Expected: one block only, no pad block.
- **Reset mid-fill.**
  - Stimulus: 7 bytes, then `rst_n_i = 0` for 1 cycle, then 16 fresh bytes.
  - Expected: the output block contains only the fresh bytes, `blk_cnt_o` restarts at 0.
- **Spurious strobes.**
  - Stimulus: pulse `enc_done_i` and `enc_busy_i` in IDLE.
  - Expected: `blk_cnt_o` and the FSM state are unchanged.
